// File: rtl/bit_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_add_ctrl (with leaf cell fullAdderStr)
// Brief    : Bit-serial adder controller. A single full-adder cell is reused
//            once per clock, LSB first, to add two WIDTH-bit operands plus a
//            carry-in. Operands arrive over a valid/ready handshake and the
//            result is held until the consumer acknowledges it.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// fullAdderStr : structural one-bit full adder (propagate/generate form)
// ----------------------------------------------------------------------------
module fullAdderStr (
  input  logic x_i,
  input  logic y_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic w_p;
  logic w_g;
  logic w_t;

  assign w_p  = x_i ^ y_i;
  assign w_g  = x_i & y_i;
  assign w_t  = w_p & ci_i;
  assign s_o  = w_p ^ ci_i;
  assign co_o = w_g | w_t;

endmodule

// ----------------------------------------------------------------------------
// bit_serial_add_ctrl : IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE
// ----------------------------------------------------------------------------
module bit_serial_add_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                 c_cnt_w    = $clog2(WIDTH);
  // Bit index of the MSB: the RUN cycle on which the final carry appears.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   sum_sh_q;
  logic               cy_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic               cout_q;
  logic               ovf_q;

  logic               w_fa_s;
  logic               w_fa_c;

  // The only arithmetic in the block: one bit of the sum per RUN cycle.
  fullAdderStr u_fa (
    .x_i  (a_sh_q[0]),
    .y_i  (b_sh_q[0]),
    .ci_i (cy_q),
    .s_o  (w_fa_s),
    .co_o (w_fa_c)
  );

  // Controller FSM with registered handshake outputs and the serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            cy_q       <= cin;
            cnt_q      <= '0;
            sum_sh_q   <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Sum bits enter at the MSB so that after WIDTH shifts bit 0 of the
          // result sits at sum_sh_q[0].
          sum_sh_q <= {w_fa_s, sum_sh_q[WIDTH-1:1]};
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          cy_q     <= w_fa_c;
          if (cnt_q == c_cnt_last) begin
            // cy_q is the carry into the MSB, w_fa_c the carry out of it.
            ovf_q       <= cy_q ^ w_fa_c;
            cout_q      <= w_fa_c;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            // Held at the last index rather than wrapping; reloaded in IDLE.
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_sh_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_add_ctrl
// Brief    : Directed and randomised checks of bit_serial_add_ctrl at
//            WIDTH=8 and WIDTH=64 using immediate assertions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;

  // WIDTH=8 instance
  logic       v8, rdy8, ci8, ov8, ordy8, co8, of8;
  logic [7:0] a8, b8, s8;

  // WIDTH=64 instance
  logic        v64, rdy64, ci64, ov64, ordy64, co64, of64;
  logic [63:0] a64, b64, s64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .in_ready  (rdy8),
    .a         (a8),
    .b         (b8),
    .cin       (ci8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .sum       (s8),
    .cout      (co8),
    .ovf       (of8)
  );

  bit_serial_add_ctrl #(.WIDTH(64)) u_dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v64),
    .in_ready  (rdy64),
    .a         (a64),
    .b         (b64),
    .cin       (ci64),
    .out_valid (ov64),
    .out_ready (ordy64),
    .sum       (s64),
    .cout      (co64),
    .ovf       (of64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input bit w);
    return w ? rdy64 : rdy8;
  endfunction

  function automatic logic get_ov(input bit w);
    return w ? ov64 : ov8;
  endfunction

  task automatic drv(input bit w, input logic v, input logic [63:0] a, input logic [63:0] b,
                     input logic ci);
    if (w) begin
      v64 = v; a64 = a; b64 = b; ci64 = ci;
    end else begin
      v8 = v; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci;
    end
  endtask

  task automatic set_ordy(input bit w, input logic val);
    if (w) ordy64 = val;
    else   ordy8  = val;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Handshake one operand set in, then wait (bounded) for out_valid.
  // noisy: wiggle in_valid/out_ready/operands while the add is running.
  task automatic do_add(input bit w, input logic [63:0] a, input logic [63:0] b, input logic ci,
                        input bit noisy, output logic [63:0] s, output logic co,
                        output logic of, output int lat);
    int  n;
    bit  ok;
    n = 0;
    while (!get_rdy(w) && n < 300) begin
      tick();
      n++;
    end
    ok = get_rdy(w);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL accept_wait: observed in_ready=0 expected in_ready=1 within 300 cycles");
    end
    drv(w, 1'b1, a, b, ci);
    tick();
    // Scramble the operand bus: it must not be re-sampled.
    drv(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    lat = 0;
    ok  = 0;
    while (lat < 300) begin
      if (get_ov(w)) begin
        ok = 1;
        break;
      end
      if (noisy) begin
        drv(w, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)));
        set_ordy(w, 1'($urandom_range(0, 1)));
      end
      tick();
      lat++;
    end
    drv(w, 1'b0, '0, '0, 1'b0);
    if (noisy) set_ordy(w, 1'b0);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL done_wait: observed out_valid=0 expected out_valid=1 within 300 cycles");
    end
    s  = w ? s64 : {56'd0, s8};
    co = w ? co64 : co8;
    of = w ? of64 : of8;
  endtask

  // Accept the result and confirm the controller is back in IDLE.
  task automatic consume(input bit w, input string tag);
    set_ordy(w, 1'b1);
    tick();
    set_ordy(w, 1'b0);
    chk({tag, "_rdy_after"}, 64'(get_rdy(w)), 64'd1);
    chk({tag, "_ov_after"},  64'(get_ov(w)),  64'd0);
  endtask

  initial begin
    logic [63:0] s;
    logic        co, of;
    int          lat;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [8:0]  r9;
    logic [63:0] qa, qb;
    logic [64:0] r65;
    bit          seen_ov;

    rst = 1'b1;
    v8 = 0; a8 = '0; b8 = '0; ci8 = 0; ordy8 = 0;
    v64 = 0; a64 = '0; b64 = '0; ci64 = 0; ordy64 = 0;
    repeat (3) tick();

    // ---- Reset state ----
    chk("rst8_rdy",  64'(rdy8),  64'd1);
    chk("rst8_ov",   64'(ov8),   64'd0);
    chk("rst8_sum",  64'(s8),    64'd0);
    chk("rst8_cout", 64'(co8),   64'd0);
    chk("rst8_ovf",  64'(of8),   64'd0);
    chk("rst64_rdy", 64'(rdy64), 64'd1);
    chk("rst64_ov",  64'(ov64),  64'd0);
    chk("rst64_sum", s64,        64'd0);
    rst = 1'b0;
    tick();

    // ---- 1: 0x35 + 0x4A, out_ready held high ----
    ordy8 = 1'b1;
    do_add(1'b0, 64'h35, 64'h4A, 1'b0, 1'b0, s, co, of, lat);
    chk("t1_lat",  64'(lat), 64'd8);
    chk("t1_sum",  s,        64'h7F);
    chk("t1_cout", 64'(co),  64'd0);
    chk("t1_ovf",  64'(of),  64'd0);
    chk("t1_rdy_in_done", 64'(rdy8), 64'd0);
    tick();
    chk("t1_rdy_next", 64'(rdy8), 64'd1);
    chk("t1_ov_next",  64'(ov8),  64'd0);
    ordy8 = 1'b0;

    // ---- 2: carry out and signed overflow ----
    do_add(1'b0, 64'hFF, 64'h01, 1'b0, 1'b0, s, co, of, lat);
    chk("t2a_sum",  s,       64'h00);
    chk("t2a_cout", 64'(co), 64'd1);
    chk("t2a_ovf",  64'(of), 64'd0);
    consume(1'b0, "t2a");
    do_add(1'b0, 64'h7F, 64'h01, 1'b0, 1'b0, s, co, of, lat);
    chk("t2b_sum",  s,       64'h80);
    chk("t2b_cout", 64'(co), 64'd0);
    chk("t2b_ovf",  64'(of), 64'd1);
    consume(1'b0, "t2b");

    // ---- 3: WIDTH=64 all-ones + 0 + cin ----
    do_add(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, s, co, of, lat);
    chk("t3_lat",  64'(lat), 64'd64);
    chk("t3_sum",  s,        64'd0);
    chk("t3_cout", 64'(co),  64'd1);
    chk("t3_ovf",  64'(of),  64'd0);
    consume(1'b1, "t3");

    // ---- 4: back-pressure with an ignored in_valid pulse ----
    do_add(1'b0, 64'h12, 64'h34, 1'b1, 1'b0, s, co, of, lat);
    for (int i = 0; i < 5; i++) begin
      chk("t4_sum",  64'(s8),   64'h47);
      chk("t4_cout", 64'(co8),  64'd0);
      chk("t4_ovf",  64'(of8),  64'd0);
      chk("t4_rdy",  64'(rdy8), 64'd0);
      chk("t4_ov",   64'(ov8),  64'd1);
      if (i == 1) begin
        v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1;
      end else begin
        v8 = 1'b0;
      end
      tick();
    end
    chk("t4_sum_release", 64'(s8), 64'h47);
    consume(1'b0, "t4");

    // ---- 5: reset at RUN cycle 3 ----
    v8 = 1'b1; a8 = 8'h55; b8 = 8'h66; ci8 = 1'b0;
    tick();
    v8 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rdy", 64'(rdy8), 64'd1);
    chk("t5_ov",  64'(ov8),  64'd0);
    rst = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ov8) seen_ov = 1'b1;
      tick();
    end
    chk("t5_no_result", 64'(seen_ov), 64'd0);
    do_add(1'b0, 64'h10, 64'h20, 1'b0, 1'b0, s, co, of, lat);
    chk("t5_sum",  s,       64'h30);
    chk("t5_cout", 64'(co), 64'd0);
    consume(1'b0, "t5");

    // ---- 6: random adds against a wide-sum reference ----
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      do_add(1'b0, {56'd0, ra}, {56'd0, rb}, rc, 1'($urandom_range(0, 1)), s, co, of, lat);
      r9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      chk("r8_sum",  s,        {56'd0, r9[7:0]});
      chk("r8_cout", 64'(co),  64'(r9[8]));
      chk("r8_ovf",  64'(of),  64'((ra[7] == rb[7]) && (r9[7] != ra[7])));
      chk("r8_lat",  64'(lat), 64'd8);
      repeat ($urandom_range(0, 3)) tick();
      consume(1'b0, "r8");
    end
    for (int i = 0; i < 300; i++) begin
      qa = {$urandom, $urandom};
      qb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      do_add(1'b1, qa, qb, rc, 1'($urandom_range(0, 1)), s, co, of, lat);
      r65 = {1'b0, qa} + {1'b0, qb} + {64'd0, rc};
      chk("r64_sum",  s,        r65[63:0]);
      chk("r64_cout", 64'(co),  64'(r65[64]));
      chk("r64_ovf",  64'(of),  64'((qa[63] == qb[63]) && (r65[63] != qa[63])));
      chk("r64_lat",  64'(lat), 64'd64);
      repeat ($urandom_range(0, 3)) tick();
      consume(1'b1, "r64");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
